// File: rtl/cheat_loader.sv
// Cheat file capture: assembles 16-byte ioctl records into 129-bit engine code words
// and hands each one off with a clean low/high/low toggle of code[128].
module cheat_loader #(
  parameter logic [7:0] CHEAT_INDEX   = 8'd255,
  parameter int         MAX_CODES     = 32,
  parameter int         STROBE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ioctl_download,
  input  logic [7:0]   ioctl_index,
  input  logic         ioctl_wr,
  input  logic [24:0]  ioctl_addr,
  input  logic [15:0]  ioctl_dout,
  output logic         ioctl_wait,
  output logic [128:0] code,
  output logic         codes_reset,
  output logic [5:0]   code_count,
  output logic         overrun
);

  localparam int              CNT_W       = $clog2(STROBE_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES);
  localparam logic [6:0]      MAX_C       = 7'(MAX_CODES);

  typedef enum logic [1:0] {IDLE, LOAD, STROBE_HI, STROBE_LO} state_t;

  state_t            state_reg, state_next;
  logic              dl_prev_reg;
  logic [15:0]       staging_reg  [8];
  logic [15:0]       staging_next [8];
  logic [127:0]      staging_flat;
  logic [7:0]        mask_reg, mask_next;
  logic              pending_reg, pending_next;
  logic [127:0]      payload_reg, payload_next;
  logic              clk_bit_reg, clk_bit_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [5:0]        count_reg, count_next;
  logic              overrun_reg, overrun_next;
  logic              codes_reset_reg, codes_reset_next;

  logic              active_wr;
  logic              dl_start;
  logic              dl_end;
  logic              in_strobe;
  logic              accept;
  logic [2:0]        word;
  logic [2:0]        lane;
  logic [7:0]        mask_after;
  logic [7:0]        lane_we;
  logic              unused_addr;

  assign unused_addr = ^{ioctl_addr[24:4], ioctl_addr[0]};

  assign active_wr  = ioctl_wr && ioctl_download && (ioctl_index == CHEAT_INDEX);
  assign dl_start   = ioctl_download && !dl_prev_reg && (ioctl_index == CHEAT_INDEX);
  assign dl_end     = !ioctl_download && dl_prev_reg;
  assign in_strobe  = (state_reg == STROBE_HI) || (state_reg == STROBE_LO);
  assign accept     = active_wr && !dl_start && !in_strobe;
  assign word       = ioctl_addr[3:1];
  assign mask_after = mask_reg | (8'd1 << word);

  // Lane L holds code bits [16L+:16]; field f of word w lands at lane 2*(3-f)+w[0],
  // which reduces to flipping the two upper bits of w.
  assign lane = word ^ 3'b110;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign lane_we[gi]      = accept && (lane == 3'(gi));
      assign staging_next[gi] = dl_start    ? 16'h0000 :
                                lane_we[gi] ? ioctl_dout : staging_reg[gi];
      assign staging_flat[16*gi +: 16] = staging_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    mask_next        = mask_reg;
    pending_next     = pending_reg;
    payload_next     = payload_reg;
    clk_bit_next     = clk_bit_reg;
    cnt_next         = cnt_reg;
    count_next       = count_reg;
    overrun_next     = overrun_reg;
    codes_reset_next = 1'b0;

    if (dl_start) begin
      // A new download aborts any handoff in flight; the payload is left alone.
      state_next       = IDLE;
      mask_next        = 8'h00;
      pending_next     = 1'b0;
      clk_bit_next     = 1'b0;
      cnt_next         = '0;
      count_next       = 6'd0;
      overrun_next     = 1'b0;
      codes_reset_next = 1'b1;
    end else begin
      case (state_reg)
        IDLE, LOAD: begin
          if (accept) begin
            state_next = LOAD;
            mask_next  = mask_after;
            if (word == 3'd7) begin
              mask_next  = 8'h00;
              state_next = IDLE;
              if (mask_after == 8'hFF) begin
                if ({1'b0, count_reg} < MAX_C) pending_next = 1'b1;
                else                           overrun_next = 1'b1;
              end
            end
          end else if (dl_end && state_reg == LOAD) begin
            mask_next  = 8'h00;
            state_next = IDLE;
          end
          // Payload latches one cycle after the final word so it settles before [128] rises.
          if (pending_reg) begin
            payload_next = staging_flat;
            pending_next = 1'b0;
            cnt_next     = '0;
            state_next   = STROBE_HI;
          end
        end
        STROBE_HI: begin
          if (cnt_reg == STROBE_LAST) begin
            clk_bit_next = 1'b0;
            cnt_next     = CNT_W'(1);
            state_next   = STROBE_LO;
          end else begin
            clk_bit_next = 1'b1;
            cnt_next     = cnt_reg + CNT_W'(1);
          end
        end
        STROBE_LO: begin
          if (cnt_reg == STROBE_LAST) begin
            count_next = count_reg + 6'd1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase

      if (active_wr && in_strobe) overrun_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      dl_prev_reg     <= 1'b0;
      mask_reg        <= 8'h00;
      pending_reg     <= 1'b0;
      payload_reg     <= '0;
      clk_bit_reg     <= 1'b0;
      cnt_reg         <= '0;
      count_reg       <= 6'd0;
      overrun_reg     <= 1'b0;
      codes_reset_reg <= 1'b0;
      for (int i = 0; i < 8; i++) staging_reg[i] <= 16'h0000;
    end else begin
      state_reg       <= state_next;
      dl_prev_reg     <= ioctl_download;
      mask_reg        <= mask_next;
      pending_reg     <= pending_next;
      payload_reg     <= payload_next;
      clk_bit_reg     <= clk_bit_next;
      cnt_reg         <= cnt_next;
      count_reg       <= count_next;
      overrun_reg     <= overrun_next;
      codes_reset_reg <= codes_reset_next;
      for (int i = 0; i < 8; i++) staging_reg[i] <= staging_next[i];
    end
  end

  assign ioctl_wait  = in_strobe;
  assign code        = {clk_bit_reg, payload_reg};
  assign codes_reset = codes_reset_reg;
  assign code_count  = count_reg;
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_cheat_loader.sv
// Directed bench for cheat_loader: expected code words are queued as records are sent
// and popped by a monitor on every rising edge of code[128].
module tb_cheat_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         ioctl_download;
  logic [7:0]   ioctl_index;
  logic         ioctl_wr;
  logic [24:0]  ioctl_addr;
  logic [15:0]  ioctl_dout;
  logic         ioctl_wait;
  logic [128:0] code;
  logic         codes_reset;
  logic [5:0]   code_count;
  logic         overrun;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q [$];
  logic         prev_bit = 1'b0;

  cheat_loader dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .code           (code),
    .codes_reset    (codes_reset),
    .code_count     (code_count),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: each rising edge of the clock bit must match the oldest queued record.
  always @(negedge clk) begin
    if (code[128] && !prev_bit) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_strobe: observed %0h expected no handoff", code[127:0]);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        check("strobe_payload", {1'b0, code[127:0]}, {1'b0, e});
        $display("handoff %0d: code=%032h", code_count, code[127:0]);
      end
    end
    prev_bit = code[128];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rec_word(input logic [127:0] rec, input int w);
    logic [31:0] fv;
    fv = rec[32*(3 - w/2) +: 32];
    return (w % 2) ? fv[31:16] : fv[15:0];
  endfunction

  task automatic write_word(input int r, input int w, input logic [15:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(r * 16 + w * 2);
    ioctl_dout = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic send_record(input int r, input logic [127:0] rec, input bit expect_handoff);
    if (expect_handoff) exp_q.push_back(rec);
    for (int w = 0; w < 8; w++) write_word(r, w, rec_word(rec, w));
  endtask

  task automatic wait_idle();
    int n;
    tick();
    tick();
    n = 0;
    while (ioctl_wait && n < 20) begin
      tick();
      n++;
    end
    check("wait_release", {128'd0, ioctl_wait}, 129'd0);
  endtask

  task automatic restart_download();
    ioctl_download = 1'b0;
    tick();
    ioctl_index    = 8'd255;
    ioctl_download = 1'b1;
    tick();
    check("restart_codes_reset", {128'd0, codes_reset}, 129'd1);
  endtask

  initial begin
    logic [127:0] r1, r2, r3, rr;
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] r1, r2, r3, rr;
    r1 = {32'h1, 32'h0000C123, 32'h55, 32'hAA};
    r2 = {32'hDEADBEEF, 32'h12345678, 32'hA5A50F0F, 32'h0BADF00D};
    r3 = {32'h00000003, 32'h00FF1234, 32'hCAFEBABE, 32'h87654321};

    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_code", code, 129'd0);
    check("reset_wait", {128'd0, ioctl_wait}, 129'd0);
    check("reset_codes_reset", {128'd0, codes_reset}, 129'd0);
    check("reset_count", {123'd0, code_count}, 129'd0);
    check("reset_overrun", {128'd0, overrun}, 129'd0);

    // Download start
    ioctl_index = 8'd255; ioctl_download = 1'b1;
    tick();
    check("start_pulse_hi", {128'd0, codes_reset}, 129'd1);
    tick();
    check("start_pulse_lo", {128'd0, codes_reset}, 129'd0);
    check("start_count", {123'd0, code_count}, 129'd0);
    check("start_code", code, 129'd0);

    // In-order record with cycle-exact handoff timing
    send_record(0, r1, 1'b1);
    tick();
    check("n1_payload", code, {1'b0, r1});
    check("n1_wait", {128'd0, ioctl_wait}, 129'd1);
    tick(); check("n2_bit", {128'd0, code[128]}, 129'd1);
    tick(); check("n3_bit", {128'd0, code[128]}, 129'd1);
    tick(); check("n4_bit", {128'd0, code[128]}, 129'd0);
    check("n4_wait", {128'd0, ioctl_wait}, 129'd1);
    tick(); check("n5_bit", {128'd0, code[128]}, 129'd0);
    check("n5_wait", {128'd0, ioctl_wait}, 129'd1);
    tick(); check("n6_wait", {128'd0, ioctl_wait}, 129'd0);
    check("n6_count", {123'd0, code_count}, 129'd1);
    check("n6_payload_hold", {1'b0, code[127:0]}, {1'b0, r1});

    // Word 7 first is incomplete; words 0..6 alone never complete; rewrite of 7 does
    write_word(1, 7, rec_word(r2, 7));
    for (int w = 0; w < 7; w++) write_word(1, w, rec_word(r2, w));
    repeat (3) tick();
    check("ooo_no_handoff_wait", {128'd0, ioctl_wait}, 129'd0);
    check("ooo_no_handoff_count", {123'd0, code_count}, 129'd1);
    exp_q.push_back(r2);
    write_word(1, 7, rec_word(r2, 7));
    wait_idle();
    check("ooo_count", {123'd0, code_count}, 129'd2);

    // Word 3 missing, then word 3 + word 7 alone: both must be rejected
    for (int w = 0; w < 8; w++) if (w != 3) write_word(2, w, rec_word(r3, w));
    repeat (3) tick();
    check("gap_wait", {128'd0, ioctl_wait}, 129'd0);
    write_word(2, 3, rec_word(r3, 3));
    write_word(2, 7, rec_word(r3, 7));
    repeat (6) tick();
    check("gap_mask_cleared_count", {123'd0, code_count}, 129'd2);
    check("gap_payload_hold", {1'b0, code[127:0]}, {1'b0, r2});

    // Non-matching index: no start pulse, writes ignored
    ioctl_download = 1'b0;
    tick();
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick();
    check("foreign_no_pulse", {128'd0, codes_reset}, 129'd0);
    send_record(3, r3, 1'b0);
    repeat (6) tick();
    check("foreign_count", {123'd0, code_count}, 129'd2);
    check("foreign_overrun", {128'd0, overrun}, 129'd0);
    check("foreign_payload", {1'b0, code[127:0]}, {1'b0, r2});

    // Write injected during the strobe
    restart_download();
    check("restart_count", {123'd0, code_count}, 129'd0);
    send_record(0, r3, 1'b1);
    tick();
    write_word(0, 0, 16'hFFFF);
    check("inject_overrun", {128'd0, overrun}, 129'd1);
    check("inject_payload", {1'b0, code[127:0]}, {1'b0, r3});
    wait_idle();
    check("inject_count", {123'd0, code_count}, 129'd1);

    // 33 records against MAX_CODES=32
    restart_download();
    check("restart_overrun", {128'd0, overrun}, 129'd0);
    for (int r = 0; r < 32; r++) begin
      rr = {$urandom, $urandom, $urandom, $urandom};
      send_record(r, rr, 1'b1);
      wait_idle();
    end
    check("max_count", {123'd0, code_count}, 129'd32);
    check("max_no_overrun_yet", {128'd0, overrun}, 129'd0);
    send_record(32, r1, 1'b0);
    wait_idle();
    repeat (4) tick();
    check("max_count_sat", {123'd0, code_count}, 129'd32);
    check("max_overrun", {128'd0, overrun}, 129'd1);

    // Reset during STROBE_HI
    restart_download();
    send_record(0, r2, 1'b1);
    tick();
    tick();
    check("pre_reset_bit", {128'd0, code[128]}, 129'd1);
    reset = 1'b1; ioctl_download = 1'b0;
    tick();
    check("midstrobe_reset_code", code, 129'd0);
    check("midstrobe_reset_wait", {128'd0, ioctl_wait}, 129'd0);
    check("midstrobe_reset_count", {123'd0, code_count}, 129'd0);
    reset = 1'b0;
    repeat (4) tick();
    check("scoreboard_empty", 129'(exp_q.size()), 129'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
